// File: rtl/corr_defs_pkg.sv
// Shared definitions for the correlation path: result width, default sample
// width, clamp ceiling and the correlator run/idle state encoding.
package corr_defs;

    localparam int CORR_W   = 10;
    localparam int SAMPLE_W = 12;
    localparam int CORR_MAX = 1023;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } corr_state_t;

endpackage

// File: rtl/sample_delay_line.sv
// Circular sample store for the correlator: one synchronous write port and
// one synchronous read port, read-before-write, no reset so it maps to BRAM.
module sample_delay_line
    import corr_defs::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write and read share the edge; the read returns the word held before this write.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/lag_correlator.sv
// Windowed autocorrelation: sums x[n]*x[n-lag] over WINDOW accepted samples,
// then scales, clamps and presents the result with a one-cycle strobe.
module lag_correlator
    import corr_defs::*;
#(
    parameter int SAMPLE_W = corr_defs::SAMPLE_W,
    parameter int DEPTH    = 512,
    parameter int WINDOW   = 1024,
    parameter int SHIFT    = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       sample_valid,
    input  logic [$clog2(DEPTH)-1:0]   lag,
    output logic [CORR_W-1:0]          correlation,
    output logic                       correlation_valid,
    output logic                       lag_err
);

    localparam int LW    = $clog2(DEPTH);
    localparam int CW    = $clog2(WINDOW);
    localparam int PW    = 2 * SAMPLE_W;
    localparam int ACC_W = PW + CW;
    localparam logic [LW:0] FILL_MAX = (LW+1)'(DEPTH);

    // Arithmetic shift, then clamp into the unsigned CORR_W output range.
    function automatic logic [CORR_W-1:0] scale_clamp(input logic signed [ACC_W-1:0] i_sum);
        logic signed [ACC_W-1:0] w_sh;
        w_sh = i_sum >>> SHIFT;
        if (w_sh[ACC_W-1]) return '0;
        if (w_sh > ACC_W'(CORR_MAX)) return CORR_W'(CORR_MAX);
        return w_sh[CORR_W-1:0];
    endfunction

    corr_state_t r_state, w_state_nxt;
    logic        w_active, w_accept;

    logic [LW-1:0] r_wptr, r_lag_q, w_lag_cur, w_raddr;
    logic [LW:0]   r_filled;
    logic [CW-1:0] r_wcnt;
    logic          r_lag_err;
    logic          w_first, w_last, w_lag_bad, w_zero;

    logic signed [SAMPLE_W-1:0] w_rdata;
    logic signed [SAMPLE_W-1:0] r_x_p0, r_a_p1, r_b_p1;
    logic                       r_zero_p0;
    logic                       r_vld_p0, r_vld_p1, r_vld_p2;
    logic                       r_last_p0, r_last_p1, r_last_p2;
    logic                       r_bad_p0, r_bad_p1, r_bad_p2;
    logic signed [PW-1:0]       r_prod_p2;
    logic signed [ACC_W-1:0]    r_acc, r_sum_p3, w_acc_nxt;
    logic                       r_done_p3;

    // State register: IDLE while enable is low, RUN otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state; a sample is accepted only in a cycle that is running.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (enable)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!enable) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        w_active = (w_state_nxt == ST_RUN);
        w_accept = w_active & sample_valid;
    end

    // The first sample of a window uses the live lag, which is latched at the same edge.
    assign w_first   = (r_wcnt == '0);
    assign w_last    = (r_wcnt == CW'(WINDOW - 1));
    assign w_lag_cur = w_first ? lag : r_lag_q;
    // The lag port cannot encode values >= DEPTH, so zero is the only illegal lag.
    assign w_lag_bad = (w_lag_cur == '0);
    assign w_zero    = w_lag_bad | (r_filled < {1'b0, w_lag_cur});
    assign w_raddr   = r_wptr - w_lag_cur;

    sample_delay_line #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_delay (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_wptr),
        .i_wdata (sample),
        .i_re    (w_accept),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Write pointer, fill level, window position and per-window lag latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_filled  <= '0;
            r_wcnt    <= '0;
            r_lag_q   <= '0;
            r_lag_err <= 1'b0;
        end else if (!w_active) begin
            r_filled  <= '0;
            r_wcnt    <= '0;
            r_lag_err <= 1'b0;
        end else if (w_accept) begin
            r_wptr <= r_wptr + LW'(1);
            r_wcnt <= r_wcnt + CW'(1);
            if (r_filled != FILL_MAX) r_filled <= r_filled + (LW+1)'(1);
            if (w_first) begin
                r_lag_q   <= lag;
                r_lag_err <= w_lag_bad;
            end
        end
    end

    // Pipeline valid/marker flags; dropping enable kills everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_last_p0 <= 1'b0;
            r_last_p1 <= 1'b0;
            r_last_p2 <= 1'b0;
            r_bad_p0  <= 1'b0;
            r_bad_p1  <= 1'b0;
            r_bad_p2  <= 1'b0;
        end else begin
            // S1: delay-line access
            r_vld_p0  <= w_accept;
            r_last_p0 <= w_last;
            r_bad_p0  <= w_lag_bad;
            // S1: operand select
            r_vld_p1  <= r_vld_p0 & w_active;
            r_last_p1 <= r_last_p0;
            r_bad_p1  <= r_bad_p0;
            // S2: multiply
            r_vld_p2  <= r_vld_p1 & w_active;
            r_last_p2 <= r_last_p1;
            r_bad_p2  <= r_bad_p1;
        end
    end

    assign w_acc_nxt = r_acc + ACC_W'(r_prod_p2);

    // Datapath registers: operands, product and completed window sum.
    always_ff @(posedge clk) begin
        // S1: delay-line access
        if (w_accept) begin
            r_x_p0    <= sample;
            r_zero_p0 <= w_zero;
        end
        // S1: operand select
        r_a_p1 <= r_x_p0;
        r_b_p1 <= r_zero_p0 ? '0 : w_rdata;
        // S2: multiply
        r_prod_p2 <= PW'(r_a_p1) * PW'(r_b_p1);
        // S3: accumulate
        if (r_vld_p2) r_sum_p3 <= w_acc_nxt;
    end

    // Accumulator reloads on the last product of a window; S4 registers the clamped result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc             <= '0;
            r_done_p3         <= 1'b0;
            correlation       <= '0;
            correlation_valid <= 1'b0;
        end else begin
            // S3: accumulate
            r_done_p3 <= w_active & r_vld_p2 & r_last_p2 & ~r_bad_p2;
            if (!w_active)     r_acc <= '0;
            else if (r_vld_p2) r_acc <= r_last_p2 ? '0 : w_acc_nxt;
            // S4: scale/clamp and output
            correlation_valid <= r_done_p3;
            if (r_done_p3) correlation <= scale_clamp(r_sum_p3);
        end
    end

    assign lag_err = r_lag_err;

endmodule

// File: doc/lag_correlator.md
# lag_correlator

Windowed autocorrelation engine that sits directly upstream of the correlation display stage. It consumes the signed, DC-removed audio sample stream and, for each window of `WINDOW` accepted samples, accumulates x[n]·x[n−lag]. It then scales and clamps the sum to 10 bits and emits it as `correlation` with a one-cycle `correlation_valid` strobe. Everything runs on the audio-side clock `clk`, so the downstream stage's clock-crossing FIFO receives at most one word per window.

## Interface
Parameters:
- `SAMPLE_W`, 12: signed sample width.
- `DEPTH`, 512: delay-line entries (power of two). Legal lags are 1..DEPTH−1.
- `WINDOW`, 1024: samples per window (power of two, ≥ 4).
- `SHIFT`, 14: right-shift applied to the window sum before clamping.

Ports (single clock; reset is asynchronous and active-high):
- `clk`  in  1  system/audio clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run when high. Deasserting it aborts the current window.
- `sample`  in  SAMPLE_W  signed two's-complement audio sample.
- `sample_valid`  in  1  sample is accepted on any cycle where this is high (every cycle is legal).
- `lag`  in  9  target period in samples (log2 DEPTH bits).
- `correlation`  out  10  clamped unsigned result. Holds its value between strobes.
- `correlation_valid`  out  1  one-cycle strobe when a new result is presented.
- `lag_err`  out  1  high for the whole of a window whose latched lag is illegal.

## Operation
- FSM states:
  - IDLE: `enable` low. Window counter, accumulator and fill counter are held at 0.
  - RUN: entered on the first cycle with `enable` high.
  - RUN→IDLE happens on `enable` low. The partial window is discarded, no strobe is produced, and the in-flight pipeline drains silently.
- Lag latch: `lag` is captured into `lag_q` when a sample is accepted with window count = 0. Changes to `lag` mid-window are ignored until the next window.
- If `lag_q` = 0 or `lag_q` ≥ DEPTH:
  - `lag_err` = 1 for that window.
  - Products are forced to 0.
  - The end-of-window strobe is suppressed.
- Delay line:
  - Circular buffer with write pointer `wptr`, which wraps modulo DEPTH.
  - On each accepted sample, `sample` is written at `wptr` and the old value at (`wptr` − `lag_q`) mod DEPTH is read. Both happen in the same cycle, and the read returns the pre-write contents.
- Fill tracking:
  - `filled` counts accepted samples and saturates at DEPTH.
  - While `filled` < `lag_q`, the delayed operand is forced to 0. The RAM itself is not reset.
- Arithmetic:
  - Product is signed 2·SAMPLE_W = 24 bits.
  - Accumulator is signed 24 + log2(WINDOW) = 34 bits. It cannot overflow.
  - Result = acc >>> SHIFT (arithmetic shift). Negative → 0; >1023 → 1023; otherwise the low 10 bits.
- End of window: the product of the WINDOW-th sample is added, the result is latched, and the accumulator reloads to 0 in the same cycle. Consecutive windows therefore have no gap.

## Timing
- Pipeline:
  - S1: RAM read/write and operand select.
  - S2: multiply.
  - S3: accumulate.
  - S4: scale/clamp and register outputs.
- `correlation_valid` rises exactly 4 cycles after the edge that accepts the WINDOW-th sample of a window.
- Back-to-back `sample_valid` at full rate is supported with no stalls.
- Reset values (asynchronous, effective immediately):
  - `correlation` = 0, `correlation_valid` = 0, `lag_err` = 0.
  - FSM = IDLE.
  - `wptr`, `filled`, window count, accumulator and pipeline valids = 0.
- Reset asserted mid-window: no strobe is ever emitted for that window.
- A `sample_valid` in the same cycle that `enable` falls is not accepted.

## Structure
- Shared package/header `corr_defs`:
  - `CORR_W` = 10 (shared with the display stage).
  - `SAMPLE_W`.
  - Clamp constant `CORR_MAX` = 1023.
- One sub-module, `sample_delay_line`: synchronous single-port-write / single-port-read RAM, DEPTH × SAMPLE_W, read-before-write. It infers BRAM.
- FSM, counters, multiplier, accumulator and clamp stay in `lag_correlator`.

## Test plan
Override parameters to WINDOW=8, SHIFT=0, DEPTH=16.
- Reset, enable, lag=2, 8 samples of +10 → one strobe with `correlation`=600: the first 2 products are 0 (unfilled), then 6×100. The next 8 samples give 800.
- Constant +20, lag=1 → window sum 2800 before clamping → `correlation`=1023. Check a strobe every 8 accepted samples at full rate, 4 cycles after each 8th sample.
- Alternating +10/−10, lag=1 → negative sum → `correlation`=0, with the strobe still present.
- lag=0 for one window, then lag=3 → `lag_err` high for exactly the first window with no strobe. The second window strobes normally. A lag change at sample 4 of the second window has no effect until the third window.
- Assert `rst` at sample 5 of a window → all outputs 0 asynchronously and no strobe. After release, the first window behaves as in scenario 1.
- Drop `enable` at sample 6, then re-raise → no strobe for the aborted window. The next full window strobes with a result counted from the fresh start.
